// File: rtl/lsu_mem_access.sv
// Load/store unit: single outstanding req/ack access to data memory with alignment
// checks, lane steering for stores, load extraction and a no-ack timeout.
module lsu_mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] daddr,
    input  logic [31:0] sdata,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        we,
    output logic [4:0]  rd,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_LB  = 6'd19;
    localparam logic [5:0] OP_LH  = 6'd20;
    localparam logic [5:0] OP_LW  = 6'd21;
    localparam logic [5:0] OP_LBU = 6'd22;
    localparam logic [5:0] OP_LHU = 6'd23;
    localparam logic [5:0] OP_SB  = 6'd24;
    localparam logic [5:0] OP_SH  = 6'd25;
    localparam logic [5:0] OP_SW  = 6'd26;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WB, S_FAULT, S_ERR} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [5:0]     r_op;
    logic [1:0]     r_off;
    logic [29:0]    r_addr;
    logic [3:0]     r_be;
    logic [31:0]    r_mwdata;
    logic [4:0]     r_rd;
    logic [31:0]    r_wdata;

    logic           w_valid_op;
    logic           w_misaligned;

    function automatic logic [3:0] f_byte_en(input logic [5:0] f_op, input logic [1:0] f_off);
        case (f_op)
            OP_SB:   f_byte_en = 4'b0001 << f_off;
            OP_SH:   f_byte_en = f_off[1] ? 4'b1100 : 4'b0011;
            OP_SW:   f_byte_en = 4'b1111;
            default: f_byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_store_lanes(input logic [5:0] f_op, input logic [31:0] f_data);
        case (f_op)
            OP_SB:   f_store_lanes = {4{f_data[7:0]}};
            OP_SH:   f_store_lanes = {2{f_data[15:0]}};
            default: f_store_lanes = f_data;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [5:0] f_op, input logic [1:0] f_off,
                                                   input logic [31:0] f_word);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (f_off)
            2'd0:    v_byte = f_word[7:0];
            2'd1:    v_byte = f_word[15:8];
            2'd2:    v_byte = f_word[23:16];
            default: v_byte = f_word[31:24];
        endcase
        v_half = f_off[1] ? f_word[31:16] : f_word[15:0];
        case (f_op)
            OP_LB:   f_load_extract = {{24{v_byte[7]}}, v_byte};
            OP_LBU:  f_load_extract = {24'd0, v_byte};
            OP_LH:   f_load_extract = {{16{v_half[15]}}, v_half};
            OP_LHU:  f_load_extract = {16'd0, v_half};
            default: f_load_extract = f_word;
        endcase
    endfunction

    always_comb begin
        w_valid_op   = (op >= OP_LB) && (op <= OP_SW);
        w_misaligned = 1'b0;
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            w_misaligned = daddr[0];
        else if ((op == OP_LW) || (op == OP_SW))
            w_misaligned = (daddr[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_off    <= '0;
            r_addr   <= '0;
            r_be     <= '0;
            r_mwdata <= '0;
            r_rd     <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start && w_valid_op) begin
                        r_op     <= op;
                        r_off    <= daddr[1:0];
                        r_addr   <= daddr[31:2];
                        r_be     <= f_byte_en(op, daddr[1:0]);
                        r_mwdata <= f_store_lanes(op, sdata);
                        r_rd     <= rd_in;
                        r_state  <= w_misaligned ? S_FAULT : S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        r_cnt <= '0;
                        if (r_op <= OP_LHU) begin
                            r_wdata <= f_load_extract(r_op, r_off, mem_rdata);
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = {r_addr, 2'b00};
    assign mem_we    = mem_req ? r_be : 4'b0000;
    assign mem_wdata = r_mwdata;
    assign we        = (r_state == S_WB) && (r_rd != 5'd0);
    assign rd        = r_rd;
    assign wdata     = r_wdata;
    assign misalign  = (r_state == S_FAULT);
    assign err       = (r_state == S_ERR);
endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed accesses push expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_lsu_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] daddr = '0;
    logic [31:0] sdata = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, mem_req, we, misalign, err;
    logic [31:0] mem_addr, mem_wdata, wdata;
    logic [3:0]  mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  rd;

    always #5 clk = ~clk;

    lsu_mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .daddr(daddr),
        .sdata(sdata), .rd_in(rd_in), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .we(we), .rd(rd),
        .wdata(wdata), .misalign(misalign), .err(err)
    );

    typedef enum int {K_MEM, K_WB, K_MIS, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        chk_d;
        logic [4:0]  r;
        int          nreq;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  ack_delay = 0;
    logic [31:0] rdata_v = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void push_mem(logic [31:0] a, logic [3:0] be, logic [31:0] d, logic chk, int nreq);
        ev_t e;
        e.kind = K_MEM; e.a = a; e.be = be; e.d = d; e.chk_d = chk; e.r = '0; e.nreq = nreq;
        exp_q.push_back(e);
    endfunction

    function automatic void push_ev(kind_t k, logic [4:0] r, logic [31:0] d, int nreq);
        ev_t e;
        e.kind = k; e.a = '0; e.be = '0; e.d = d; e.chk_d = 1'b0; e.r = r; e.nreq = nreq;
        exp_q.push_back(e);
    endfunction

    // Memory model: acks on the (ack_delay+1)-th cycle of each request.
    int rcnt = 0;
    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            mem_ack   = (rcnt == ack_delay);
            mem_rdata = rdata_v;
            rcnt++;
        end else begin
            mem_ack = 1'b0;
            rcnt    = 0;
        end
    end

    int   run = 0;
    int   last_run = 0;
    logic prev_req = 1'b0;

    task automatic take(input kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, expected none", k);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(k), 32'(e.kind));
        if (k != e.kind) return;
        case (k)
            K_MEM: begin
                check("mem_addr", mem_addr, e.a);
                check("mem_we", {28'd0, mem_we}, {28'd0, e.be});
                if (e.chk_d) check("mem_wdata", mem_wdata, e.d);
                check("req_cycles", run, e.nreq);
            end
            K_WB: begin
                check("wb_rd", {27'd0, rd}, {27'd0, e.r});
                check("wb_data", wdata, e.d);
            end
            K_ERR:   check("timeout_req_cycles", last_run, e.nreq);
            default: check("misalign_no_req", {31'd0, mem_req}, 32'd0);
        endcase
    endtask

    always @(negedge clk) begin
        if (mem_req) run++;
        else begin
            if (prev_req) last_run = run;
            run = 0;
        end
        prev_req = mem_req;
        if (mem_req && mem_ack) take(K_MEM);
        if (we) take(K_WB);
        if (misalign) take(K_MIS);
        if (err) take(K_ERR);
    end

    task automatic access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r, input int d, input logic [31:0] rdv, input int exp_busy);
        int cnt;
        ack_delay = d; rdata_v = rdv;
        op = o; daddr = a; sdata = sd; rd_in = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, exp_busy);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_we_rd", {26'd0, we, rd}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_flags", {30'd0, misalign, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Loads
        push_mem(32'h100, 4'b0000, 0, 1'b0, 1); push_ev(K_WB, 5, 32'hDEADBEEF, 0);
        access(6'd21, 32'h100, 0, 5, 0, 32'hDEADBEEF, 2);
        push_mem(32'h100, 4'b0000, 0, 1'b0, 1); push_ev(K_WB, 7, 32'hFFFFFF80, 0);
        access(6'd19, 32'h103, 0, 7, 0, 32'h80FF1234, 2);
        push_mem(32'h100, 4'b0000, 0, 1'b0, 1); push_ev(K_WB, 7, 32'h00000080, 0);
        access(6'd22, 32'h103, 0, 7, 0, 32'h80FF1234, 2);
        push_mem(32'h100, 4'b0000, 0, 1'b0, 1); push_ev(K_WB, 8, 32'h000080FF, 0);
        access(6'd23, 32'h102, 0, 8, 0, 32'h80FF1234, 2);
        push_mem(32'h100, 4'b0000, 0, 1'b0, 2); push_ev(K_WB, 8, 32'hFFFF80FF, 0);
        access(6'd20, 32'h102, 0, 8, 1, 32'h80FF1234, 3);
        push_mem(32'h100, 4'b0000, 0, 1'b0, 1); push_ev(K_WB, 3, 32'h00000012, 0);
        access(6'd19, 32'h101, 0, 3, 0, 32'h80FF1234, 2);
        push_mem(32'h120, 4'b0000, 0, 1'b0, 1);
        access(6'd21, 32'h120, 0, 0, 0, 32'h55555555, 2);

        // Stores
        push_mem(32'h200, 4'b0010, 32'hABABABAB, 1'b1, 1);
        access(6'd24, 32'h201, 32'h000000AB, 4, 0, 0, 1);
        push_mem(32'h200, 4'b1100, 32'hCDEFCDEF, 1'b1, 2);
        access(6'd25, 32'h202, 32'h1234CDEF, 4, 1, 0, 2);
        push_mem(32'h204, 4'b1111, 32'h11223344, 1'b1, 1);
        access(6'd26, 32'h204, 32'h11223344, 4, 0, 0, 1);

        // Misaligned
        push_ev(K_MIS, 0, 0, 0);
        access(6'd21, 32'h102, 0, 5, 0, 0, 1);
        push_ev(K_MIS, 0, 0, 0);
        access(6'd25, 32'h201, 32'hFFFF, 5, 0, 0, 1);

        // Timeout, then ack on the last allowed cycle
        push_ev(K_ERR, 0, 0, TO);
        access(6'd21, 32'h300, 0, 9, 1000, 0, TO + 1);
        push_mem(32'h300, 4'b0000, 0, 1'b0, TO); push_ev(K_WB, 9, 32'hCAFEF00D, 0);
        access(6'd21, 32'h300, 0, 9, TO - 1, 32'hCAFEF00D, TO + 1);

        // Invalid ops are ignored
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 6'd18 : 6'd27; daddr = 32'h100; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("invalid_op_busy", {31'd0, busy}, 32'd0);
        end

        // Reset during REQ abandons the access
        ack_delay = 1000; op = 6'd21; daddr = 32'h400; rd_in = 10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // start while busy is ignored
        push_mem(32'h100, 4'b0000, 0, 1'b0, 3); push_ev(K_WB, 6, 32'h01020304, 0);
        ack_delay = 2; rdata_v = 32'h01020304;
        op = 6'd21; daddr = 32'h100; rd_in = 6; start = 1'b1;
        @(negedge clk);
        op = 6'd26; daddr = 32'h500; sdata = 32'h99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_ignored_start", cnt, 4);
        repeat (4) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
